ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-delivery stage feeding the EX-stage ALU (add/logic/compare/shift units).
//  Registers one decoded instruction and presents the final ALU operands A/B and the ALUFun code.
//  A carries the shift amount for shifts, B the value to shift.
//  Resolves RAW hazards on rs/rt by WB refresh, optional MEM/WB bypass and stalling.
//  Uses a valid/ready handshake upstream (ID) and downstream (EX).
// PARAMETERS
//  DW    32  datapath width
//  RAW    5  register address width
//  FW     6  ALUFun width
// PORTS
//  clk            in   1    clock
//  reset          in   1    asynchronous, active-low reset
//  id_valid       in   1    ID presents an instruction
//  id_ready       out  1    stage accepts this cycle
//  id_rs_addr     in   RAW  rs index
//  id_rt_addr     in   RAW  rt index
//  id_rs_data     in   DW   rs value from register file
//  id_rt_data     in   DW   rt value from register file
//  id_imm         in   DW   extended immediate
//  id_shamt       in   5    shift amount field
//  id_alusrc1     in   1    1: A = {27'b0,shamt}; 0: A = rs
//  id_alusrc2     in   1    1: B = imm; 0: B = rt
//  id_alu_fun     in   FW   ALU function code (passed through)
//  id_rd_addr     in   RAW  destination index (passed through)
//  id_mem_read    in   1    instruction is a load (passed through)
//  flush          in   1    squash held and incoming instruction
//  ex_ready       in   1    EX consumes this cycle
//  ex_valid       out  1    operands valid
//  ex_a           out  DW   ALU operand A
//  ex_b           out  DW   ALU operand B
//  ex_alu_fun     out  FW   ALU function code
//  ex_rd_addr     out  RAW  destination index
//  ex_mem_read    out  1    load flag
//  mem_wr_en      in   1    MEM-stage instruction writes a register
//  mem_rd_addr    in   RAW  MEM-stage destination
//  mem_result     in   DW   MEM-stage ALU result
//  mem_is_load    in   1    MEM-stage instruction is a load; data not yet available
//  wb_wr_en       in   1    WB register-file write enable
//  wb_rd_addr     in   RAW  WB destination
//  wb_result      in   DW   WB write data
// BEHAVIOUR
//  - Reset, asynchronous: valid bit v=0 and all held fields 0.
//    While v=0, every output is 0 except id_ready=1.
//  - Definitions:
//    - fire = ex_valid & ex_ready.
//    - id_ready = ~flush & (~v | fire).
//    - Capture on id_valid & id_ready: all fields loaded, v<=1.
//    - On fire with no capture: v<=0.
//    - Latency: 1 cycle from capture to ex_valid.
//  - flush: ex_valid=0 the same cycle; v<=0 next edge.
//    flush overrides a simultaneous capture and fire.
//  - WB refresh (always built in):
//    - Applies on the capture edge and on every edge while v=1.
//    - If wb_wr_en & wb_rd_addr==held/incoming rs (or rt) & addr!=0, that operand register <= wb_result.
//    - This models register-file write-during-read.
//  - Hazards:
//    - rs is checked only if ~alusrc1; rt only if ~alusrc2.
//    - Register 0 never matches.
//    - Any hazard forces ex_valid=0 and holds the stage.
//  - Output muxes:
//    - ex_a = alusrc1 ? {27'b0,shamt} : rs_op.
//    - ex_b = alusrc2 ? imm : rt_op.
//    - alu_fun, rd_addr and mem_read are registered passthrough and are stable while ~fire.
// CONFIGURATION
//  ALU_FWD_EN defined:
//    - rs_op/rt_op = MEM match ? mem_result : WB match ? wb_result : held value.
//    - MEM has priority over WB.
//    - Hazard only on a MEM match with mem_is_load (load-use): 1 stall cycle, then the WB refresh/bypass supplies the value.
//  ALU_FWD_EN undefined:
//    - rs_op/rt_op = held value.
//    - Hazard on any MEM match or WB match; the stage stalls until the WB refresh lands.
//    - MEM hit: 2 stall cycles. WB hit: 1 stall cycle.
// STRUCTURE
//  - Package alu_pkg:
//    - DW, RAW and FW constants.
//    - ALUFun localparams, including shift codes SLL=00, SRL=01, SRA=11 in bits [1:0].
//    - Operand-select enum.
//  - Sub-module operand_fwd_mux (one per operand):
//    - Does match detection, the priority mux and the hazard flag.
//    - Contents are selected by ALU_FWD_EN.
// TESTING
//  1. Reset asserted with v=1 mid-stream -> ex_valid=0 and ex_a=ex_b=0 immediately. After release, id_ready=1.
//  2. SLL with alusrc1=1, shamt=4, rt data 0x00000001 -> next cycle ex_valid=1, ex_a=0x4, ex_b=0x1, ex_alu_fun unchanged.
//  3. rs=8 held stale 0 while mem_wr_en=1, mem_rd_addr=8, mem_result=0xDEADBEEF:
//     -> FWD_EN: ex_a=0xDEADBEEF same cycle, no stall.
//     -> no FWD_EN: ex_valid=0 until WB writes 8, then ex_a=0xDEADBEEF.
//  4. Load-use with mem_is_load=1 matching rt -> ex_valid=0 and id_ready=0 for 1 cycle.
//     Next cycle WB supplies 0x1234 -> ex_b=0x1234, ex_valid=1.
//  5. ex_ready=0 for 3 cycles -> outputs stable, id_ready=0. ex_ready=1 -> fire and simultaneous capture of the next instruction.
//  6. flush together with id_valid=1 -> no capture, ex_valid=0, next cycle v=0.
//     Also: rs=0 with mem_wr_en=1, mem_rd_addr=0 -> ex_a=0 and no stall.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, ALU function codes and operand-select enum for the EX stage.
// Imported by operand_fwd_mux and ex_operand_stage.
package alu_pkg;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int FW  = 6;
    localparam int SHW = 5;

    localparam logic [FW-1:0] ALU_ADD = 6'b000000;
    localparam logic [FW-1:0] ALU_SUB = 6'b000001;
    localparam logic [FW-1:0] ALU_AND = 6'b011000;
    localparam logic [FW-1:0] ALU_OR  = 6'b011110;
    localparam logic [FW-1:0] ALU_XOR = 6'b010110;
    localparam logic [FW-1:0] ALU_NOR = 6'b010001;
    localparam logic [FW-1:0] ALU_A   = 6'b011010;
    // Shift group: bits [1:0] pick SLL=00, SRL=01, SRA=11
    localparam logic [FW-1:0] ALU_SLL = 6'b100000;
    localparam logic [FW-1:0] ALU_SRL = 6'b100001;
    localparam logic [FW-1:0] ALU_SRA = 6'b100011;
    localparam logic [FW-1:0] ALU_EQ  = 6'b110011;
    localparam logic [FW-1:0] ALU_NEQ = 6'b110001;
    localparam logic [FW-1:0] ALU_LT  = 6'b110101;

    typedef enum logic [1:0] {
        OPSEL_REG = 2'd0,
        OPSEL_MEM = 2'd1,
        OPSEL_WB  = 2'd2
    } opsel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand MEM/WB match detection, bypass priority mux and RAW hazard flag.
// Ports: i_check_en/i_addr/i_held (operand), i_mem_*, i_wb_* (producers), o_data, o_hazard.
// Build option ALU_FWD_EN: bypass MEM/WB results; otherwise stall until WB refresh.
module operand_fwd_mux
    import alu_pkg::*;
#(
    parameter int DW  = alu_pkg::DW,
    parameter int RAW = alu_pkg::RAW
) (
    input  logic           i_check_en,
    input  logic [RAW-1:0] i_addr,
    input  logic [DW-1:0]  i_held,
    input  logic           i_mem_wr_en,
    input  logic [RAW-1:0] i_mem_rd_addr,
    input  logic [DW-1:0]  i_mem_result,
    input  logic           i_mem_is_load,
    input  logic           i_wb_wr_en,
    input  logic [RAW-1:0] i_wb_rd_addr,
    input  logic [DW-1:0]  i_wb_result,
    output logic [DW-1:0]  o_data,
    output logic           o_hazard
);

    logic w_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hardwired and never produces a dependency
    assign w_nz      = |i_addr;
    assign w_mem_hit = i_check_en & w_nz & i_mem_wr_en &
                       (i_mem_rd_addr == i_addr);
    assign w_wb_hit  = i_check_en & w_nz & i_wb_wr_en &
                       (i_wb_rd_addr == i_addr);

`ifdef ALU_FWD_EN
    opsel_e w_sel;

    always_comb begin
        w_sel = OPSEL_REG;
        if (w_mem_hit)
            w_sel = OPSEL_MEM;
        else if (w_wb_hit)
            w_sel = OPSEL_WB;
    end

    always_comb begin
        o_data = i_held;
        unique case (w_sel)
            OPSEL_MEM: o_data = i_mem_result;
            OPSEL_WB:  o_data = i_wb_result;
            default:   o_data = i_held;
        endcase
    end

    // A load in MEM has no data yet: one bubble, then WB bypass
    assign o_hazard = w_mem_hit & i_mem_is_load;
`else
    logic w_unused;

    assign o_data   = i_held;
    assign o_hazard = w_mem_hit | w_wb_hit;
    assign w_unused = ^{i_mem_result, i_mem_is_load, i_wb_result};
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register delivering ALU operands A/B and ALUFun with RAW hazard handling.
// Ports: clk, reset (async active-low), id_* (upstream v/r), ex_* (downstream v/r),
// flush, mem_* and wb_* producer taps. Build option ALU_FWD_EN enables bypassing.
module ex_operand_stage
    import alu_pkg::*;
#(
    parameter int DW  = alu_pkg::DW,
    parameter int RAW = alu_pkg::RAW,
    parameter int FW  = alu_pkg::FW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           id_valid,
    output logic           id_ready,
    input  logic [RAW-1:0] id_rs_addr,
    input  logic [RAW-1:0] id_rt_addr,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic [4:0]     id_shamt,
    input  logic           id_alusrc1,
    input  logic           id_alusrc2,
    input  logic [FW-1:0]  id_alu_fun,
    input  logic [RAW-1:0] id_rd_addr,
    input  logic           id_mem_read,
    input  logic           flush,
    input  logic           ex_ready,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_a,
    output logic [DW-1:0]  ex_b,
    output logic [FW-1:0]  ex_alu_fun,
    output logic [RAW-1:0] ex_rd_addr,
    output logic           ex_mem_read,
    input  logic           mem_wr_en,
    input  logic [RAW-1:0] mem_rd_addr,
    input  logic [DW-1:0]  mem_result,
    input  logic           mem_is_load,
    input  logic           wb_wr_en,
    input  logic [RAW-1:0] wb_rd_addr,
    input  logic [DW-1:0]  wb_result
);

    logic           r_v;
    logic [RAW-1:0] r_rs_addr;
    logic [RAW-1:0] r_rt_addr;
    logic [DW-1:0]  r_rs_data;
    logic [DW-1:0]  r_rt_data;
    logic [DW-1:0]  r_imm;
    logic [4:0]     r_shamt;
    logic           r_alusrc1;
    logic           r_alusrc2;
    logic [FW-1:0]  r_alu_fun;
    logic [RAW-1:0] r_rd_addr;
    logic           r_mem_read;

    logic          w_rs_haz;
    logic          w_rt_haz;
    logic [DW-1:0] w_rs_op;
    logic [DW-1:0] w_rt_op;
    logic          w_ex_valid;
    logic          w_fire;
    logic          w_id_ready;
    logic          w_capture;
    logic          w_rs_wb_in;
    logic          w_rt_wb_in;
    logic          w_rs_wb_held;
    logic          w_rt_wb_held;

    operand_fwd_mux #(.DW(DW), .RAW(RAW)) u_rs_mux (
        .i_check_en   (~r_alusrc1),
        .i_addr       (r_rs_addr),
        .i_held       (r_rs_data),
        .i_mem_wr_en  (mem_wr_en),
        .i_mem_rd_addr(mem_rd_addr),
        .i_mem_result (mem_result),
        .i_mem_is_load(mem_is_load),
        .i_wb_wr_en   (wb_wr_en),
        .i_wb_rd_addr (wb_rd_addr),
        .i_wb_result  (wb_result),
        .o_data       (w_rs_op),
        .o_hazard     (w_rs_haz)
    );

    operand_fwd_mux #(.DW(DW), .RAW(RAW)) u_rt_mux (
        .i_check_en   (~r_alusrc2),
        .i_addr       (r_rt_addr),
        .i_held       (r_rt_data),
        .i_mem_wr_en  (mem_wr_en),
        .i_mem_rd_addr(mem_rd_addr),
        .i_mem_result (mem_result),
        .i_mem_is_load(mem_is_load),
        .i_wb_wr_en   (wb_wr_en),
        .i_wb_rd_addr (wb_rd_addr),
        .i_wb_result  (wb_result),
        .o_data       (w_rt_op),
        .o_hazard     (w_rt_haz)
    );

    assign w_ex_valid = r_v & ~flush & ~(w_rs_haz | w_rt_haz);
    assign w_fire     = w_ex_valid & ex_ready;
    assign w_id_ready = ~flush & (~r_v | w_fire);
    assign w_capture  = id_valid & w_id_ready;

    // Register-file write-during-read: WB data replaces the read/held value
    assign w_rs_wb_in   = wb_wr_en & (|id_rs_addr) & (wb_rd_addr == id_rs_addr);
    assign w_rt_wb_in   = wb_wr_en & (|id_rt_addr) & (wb_rd_addr == id_rt_addr);
    assign w_rs_wb_held = wb_wr_en & (|r_rs_addr) & (wb_rd_addr == r_rs_addr);
    assign w_rt_wb_held = wb_wr_en & (|r_rt_addr) & (wb_rd_addr == r_rt_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v        <= 1'b0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_shamt    <= '0;
            r_alusrc1  <= 1'b0;
            r_alusrc2  <= 1'b0;
            r_alu_fun  <= '0;
            r_rd_addr  <= '0;
            r_mem_read <= 1'b0;
        end else if (w_capture) begin
            r_v        <= 1'b1;
            r_rs_addr  <= id_rs_addr;
            r_rt_addr  <= id_rt_addr;
            r_rs_data  <= w_rs_wb_in ? wb_result : id_rs_data;
            r_rt_data  <= w_rt_wb_in ? wb_result : id_rt_data;
            r_imm      <= id_imm;
            r_shamt    <= id_shamt;
            r_alusrc1  <= id_alusrc1;
            r_alusrc2  <= id_alusrc2;
            r_alu_fun  <= id_alu_fun;
            r_rd_addr  <= id_rd_addr;
            r_mem_read <= id_mem_read;
        end else begin
            if (flush || w_fire)
                r_v <= 1'b0;
            if (r_v && w_rs_wb_held)
                r_rs_data <= wb_result;
            if (r_v && w_rt_wb_held)
                r_rt_data <= wb_result;
        end
    end

    assign id_ready    = w_id_ready;
    assign ex_valid    = w_ex_valid;
    assign ex_a        = !r_v ? '0 :
                         r_alusrc1 ? {{(DW-5){1'b0}}, r_shamt} : w_rs_op;
    assign ex_b        = !r_v ? '0 : r_alusrc2 ? r_imm : w_rt_op;
    assign ex_alu_fun  = r_v ? r_alu_fun : '0;
    assign ex_rd_addr  = r_v ? r_rd_addr : '0;
    assign ex_mem_read = r_v & r_mem_read;

endmodule
